adc_sample_arbiter: RTL and testbench

ADC_SAMPLE_ARBITER -- requirements
Module: adc_sample_arbiter

---
 rtl/adc_sample_arbiter.sv | 137 +++++++++++++
 tb/tb_adc_sample_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_arbiter.sv
// Round-robin arbiter sharing one ADC conversion engine among NUM_REQ requesters.
// Optional build macro ADC_ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
module adc_sample_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_chan,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [11:0]            rsp_data,
  output logic [2:0]             rsp_chan,
  output logic                   rsp_err,
  output logic                   adc_start,
  output logic [2:0]             adc_chan,
  input  logic                   adc_done,
  input  logic [11:0]            adc_data
);

  localparam int unsigned GRANT_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT == 0) begin : g_bad_params
    $error("adc_sample_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [GRANT_W-1:0] last_grant;
  logic [GRANT_W-1:0] grant;
  logic [GRANT_W-1:0] next_grant;
  logic               any_req;
  logic [2:0]         chan_sel;

`ifdef ADC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin search starting just after last_grant; the lowest offset wins.
  always_comb begin : p_arb
    int unsigned idx;
    idx        = 0;
    next_grant = '0;
    any_req    = 1'b0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (req_valid[GRANT_W'(idx)]) begin
        next_grant = GRANT_W'(idx);
        any_req    = 1'b1;
      end
    end
  end

  always_comb begin : p_chan_sel
    chan_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == next_grant) chan_sel = req_chan[3*i +: 3];
    end
  end

  // Accept is a same-cycle handshake: a requester dropping req_valid is never granted.
  always_comb begin : p_ready
    req_ready = '0;
    if (state == IDLE && any_req) req_ready = NUM_REQ'(1) << next_grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_W'(NUM_REQ - 1);
      grant      <= '0;
      adc_start  <= 1'b0;
      adc_chan   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_chan   <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      adc_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= next_grant;
            adc_chan  <= chan_sel;
            adc_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef ADC_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (adc_done) begin
            rsp_valid <= NUM_REQ'(1) << grant;
            rsp_data  <= adc_data;
            rsp_chan  <= adc_chan;
`ifdef ADC_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef ADC_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Counter reaches TIMEOUT on this edge: abort with an error result.
            wait_cnt  <= wait_cnt + CNT_W'(1);
            rsp_valid <= NUM_REQ'(1) << grant;
            rsp_data  <= 12'hFFF;
            rsp_chan  <= adc_chan;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_arbiter.sv
// Directed, table-driven bench for adc_sample_arbiter (NUM_REQ = 4, TIMEOUT = 8).
module tb_adc_sample_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [11:0] req_chan;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic [2:0]  rsp_chan;
  logic        rsp_err;
  logic        adc_start;
  logic [2:0]  adc_chan;
  logic        adc_done;
  logic [11:0] adc_data;

  adc_sample_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_chan(req_chan), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_chan(rsp_chan), .rsp_err(rsp_err),
    .adc_start(adc_start), .adc_chan(adc_chan), .adc_done(adc_done), .adc_data(adc_data)
  );

  typedef struct {
    logic [3:0]  rv;
    logic [11:0] chans;
    int          dly;
    logic [11:0] data;
    int          g;
    logic [2:0]  ch;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int accept_cyc = 0;

  initial clock = 1'b0;
  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; adc_done = 1'b0; adc_data = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Waits (bounded) for an accept pulse; returns at the negedge of the accept cycle.
  task automatic wait_accept(output int waited);
    waited = 0;
    @(negedge clock);
    while (req_ready == 4'b0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    accept_cyc = cyc;
  endtask

  // One full conversion: accept, issue, engine answers dly cycles after adc_start, response.
  task automatic run_txn(input vec_t v);
    int waited;
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << v.g;
    @(posedge clock); #1;
    req_valid = v.rv; req_chan = v.chans;
    wait_accept(waited);
    check("accept_wait", 32'(waited), 32'd0);
    check("req_ready", 32'(req_ready), 32'(exp_oh));
    @(negedge clock);
    check("adc_start", 32'(adc_start), 32'd1);
    check("adc_chan", 32'(adc_chan), 32'(v.ch));
    check("req_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < v.dly; i++) begin
      @(posedge clock); #1;
      if (i == v.dly - 1) begin adc_done = 1'b1; adc_data = v.data; end
      @(negedge clock);
      check("no_early_rsp", 32'(rsp_valid), 32'd0);
    end
    check("adc_start_once", 32'(adc_start), 32'd0);
    @(posedge clock); #1;
    adc_done = 1'b0; adc_data = 12'h5A5;
    @(negedge clock);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
    check("rsp_data", 32'(rsp_data), 32'(v.data));
    check("rsp_chan", 32'(rsp_chan), 32'(v.ch));
    check("rsp_err", 32'(rsp_err), 32'd0);
    check("rsp_latency", 32'(cyc - accept_cyc), 32'(v.dly + 2));
  endtask

  localparam logic [11:0] CH = {3'd4, 3'd2, 3'd6, 3'd1};  // ch3=4 ch2=2 ch1=6 ch0=1

  vec_t vecs[10];
  vec_t one;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    int waited;
    int prev_accept;
    int seen;
    // All four held valid after reset: 0,1,2,3,0; then 2 alone, {2,3} pairs, {0,1} pairs.
    vecs[0] = '{4'b1111, CH, 1, 12'h111, 0, 3'd1};
    vecs[1] = '{4'b1111, CH, 2, 12'h222, 1, 3'd6};
    vecs[2] = '{4'b1111, CH, 3, 12'h333, 2, 3'd2};
    vecs[3] = '{4'b1111, CH, 1, 12'h444, 3, 3'd4};
    vecs[4] = '{4'b1111, CH, 2, 12'h555, 0, 3'd1};
    vecs[5] = '{4'b0100, CH, 1, 12'h666, 2, 3'd2};
    vecs[6] = '{4'b1100, CH, 2, 12'h777, 3, 3'd4};
    vecs[7] = '{4'b1100, CH, 1, 12'h888, 2, 3'd2};
    vecs[8] = '{4'b0011, CH, 1, 12'h999, 0, 3'd1};
    vecs[9] = '{4'b0011, CH, 4, 12'hAAA, 1, 3'd6};

    req_chan = '0;
    do_reset();
    @(negedge clock);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_adc_start", 32'(adc_start), 32'd0);
    check("reset_adc_chan", 32'(adc_chan), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_chan", 32'(rsp_chan), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);

    // Single request, engine answers two cycles after adc_start.
    one = '{4'b0001, {9'd0, 3'd3}, 2, 12'hABC, 0, 3'd3};
    run_txn(one);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("hold_rsp_data", 32'(rsp_data), 32'hABC);
    check("hold_rsp_chan", 32'(rsp_chan), 32'd3);
    // adc_done while IDLE must be ignored.
    @(posedge clock); #1;
    adc_done = 1'b1; adc_data = 12'h123;
    @(posedge clock); #1;
    adc_done = 1'b0;
    @(negedge clock);
    check("stray_done_rsp", 32'(rsp_valid), 32'd0);
    check("stray_done_data", 32'(rsp_data), 32'hABC);

    do_reset();
    prev_accept = 0;
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i]);
      if (i > 0) check("accept_spacing", 32'(accept_cyc - prev_accept), 32'(vecs[i-1].dly + 3));
      prev_accept = accept_cyc;
    end

    // Reset during WAIT drops the transaction; a later adc_done produces nothing.
    @(posedge clock); #1;
    req_valid = 4'b0010;
    wait_accept(waited);
    check("rst_mid_accept", 32'(req_ready), 32'b0010);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1; req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0; adc_done = 1'b1; adc_data = 12'hDEF;
    @(posedge clock); #1;
    adc_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rsp_valid != 4'b0 || adc_start) seen++;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'd0);
    check("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
    one = '{4'b1111, CH, 1, 12'h0F0, 0, 3'd1};
    run_txn(one);

    // Engine never answers.
    @(posedge clock); #1;
    req_valid = 4'b0001;
    wait_accept(waited);
    check("to_accept", 32'(req_ready), 32'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    seen = 0;
    while (rsp_valid == 4'b0 && seen < 40) begin
      @(negedge clock);
      seen++;
    end
`ifdef ADC_ARB_TIMEOUT_EN
    check("to_latency", 32'(cyc - accept_cyc), 32'd10);
    check("to_rsp_valid", 32'(rsp_valid), 32'b0001);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_data", 32'(rsp_data), 32'hFFF);
    check("to_rsp_chan", 32'(rsp_chan), 32'd1);
`else
    check("no_rsp_without_timeout", 32'(rsp_valid), 32'd0);
    check("rsp_err_const", 32'(rsp_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
